// File: rtl/csr_rmw_if.sv
// CSR read-modify-write controller bus bundle: decoded request in, CSR-file
// read/write port, and the response back to the pipeline.
// master = execute stage plus CSR file side, slave = the controller.
interface csr_rmw_if #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_funct3;
    logic [CSR_ADDR_W-1:0] req_csr_addr;
    logic [XLEN-1:0]       req_rs1_val;
    logic [4:0]            req_zimm;
    logic                  req_rs1_is_x0;
    logic                  req_rd_is_x0;

    logic                  csr_rd_en;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [XLEN-1:0]       csr_rd_data;
    logic                  csr_rd_valid;
    logic                  csr_rd_err;
    logic                  csr_wr_en;
    logic [XLEN-1:0]       csr_wr_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [XLEN-1:0]       rsp_rd_data;
    logic                  rsp_illegal;

    modport master (
        output req_valid, req_funct3, req_csr_addr, req_rs1_val, req_zimm,
               req_rs1_is_x0, req_rd_is_x0,
        input  req_ready,
        input  csr_rd_en, csr_addr, csr_wr_en, csr_wr_data,
        output csr_rd_data, csr_rd_valid, csr_rd_err,
        input  rsp_valid, rsp_rd_data, rsp_illegal,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_funct3, req_csr_addr, req_rs1_val, req_zimm,
               req_rs1_is_x0, req_rd_is_x0,
        output req_ready,
        output csr_rd_en, csr_addr, csr_wr_en, csr_wr_data,
        input  csr_rd_data, csr_rd_valid, csr_rd_err,
        output rsp_valid, rsp_rd_data, rsp_illegal,
        input  rsp_ready
    );
endinterface

// File: rtl/csr_rmw_ctrl.sv
// Read-modify-write sequencer for CSRRW/S/C(I): reads the CSR, computes the
// new value, writes it back when needed and returns the old value for rd.
// All outputs are registered and updated on the same edge as the state.
module csr_rmw_ctrl #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12,
    parameter int RD_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    csr_rmw_if.slave  bus
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                state;
    logic [1:0]            kind_q;      // funct3[1:0]: 01 RW, 10 RS, 11 RC
    logic [CSR_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]       op_q;
    logic                  src_zero_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [XLEN-1:0]       new_q;
    logic [XLEN-1:0]       rdat_q;
    logic                  req_ready_q, rd_en_q, wr_en_q, rsp_valid_q, illegal_q;

    logic [XLEN-1:0]       op_in;
    logic                  src_zero_in;
    logic                  ro_in;
    logic                  ro_q;
    logic [XLEN-1:0]       new_val;
    logic                  wr_needed;

    // Operand selection for an incoming request; immediate forms use zimm.
    assign op_in       = bus.req_funct3[2] ? {{(XLEN-5){1'b0}}, bus.req_zimm} : bus.req_rs1_val;
    assign src_zero_in = bus.req_funct3[2] ? (bus.req_zimm == 5'd0) : bus.req_rs1_is_x0;
    // Top two address bits 11 mark a read-only CSR.
    assign ro_in       = (bus.req_csr_addr[CSR_ADDR_W-1 -: 2] == 2'b11);
    assign ro_q        = (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11);

    // New CSR value and whether a write is architecturally required.
    always_comb begin
        new_val   = op_q;
        wr_needed = 1'b1;
        case (kind_q)
            2'b10: begin
                new_val   = bus.csr_rd_data | op_q;
                wr_needed = !src_zero_q;
            end
            2'b11: begin
                new_val   = bus.csr_rd_data & ~op_q;
                wr_needed = !src_zero_q;
            end
            default: begin
                new_val   = op_q;
                wr_needed = 1'b1;
            end
        endcase
    end

    // Main sequencer with registered handshake and CSR-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            kind_q      <= '0;
            addr_q      <= '0;
            op_q        <= '0;
            src_zero_q  <= 1'b0;
            cnt_q       <= '0;
            new_q       <= '0;
            rdat_q      <= '0;
            req_ready_q <= 1'b1;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    kind_q      <= bus.req_funct3[1:0];
                    addr_q      <= bus.req_csr_addr;
                    op_q        <= op_in;
                    src_zero_q  <= src_zero_in;
                    cnt_q       <= '0;
                    req_ready_q <= 1'b0;
                    rdat_q      <= '0;
                    illegal_q   <= 1'b0;
                    if (bus.req_funct3[1:0] == 2'b00) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        illegal_q   <= 1'b1;
                    end else if (bus.req_funct3[1:0] == 2'b01 && bus.req_rd_is_x0) begin
                        // Read skipped entirely; the write is unconditional.
                        if (ro_in) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            illegal_q   <= 1'b1;
                        end else begin
                            state   <= WRITE;
                            wr_en_q <= 1'b1;
                            new_q   <= op_in;
                        end
                    end else begin
                        state   <= READ;
                        rd_en_q <= 1'b1;
                    end
                end
                READ: begin
                    if (bus.csr_rd_valid) begin
                        rd_en_q <= 1'b0;
                        if (bus.csr_rd_err || (wr_needed && ro_q)) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            illegal_q   <= 1'b1;
                        end else begin
                            rdat_q <= bus.csr_rd_data;
                            if (wr_needed) begin
                                state   <= WRITE;
                                wr_en_q <= 1'b1;
                                new_q   <= new_val;
                            end else begin
                                state       <= RESP;
                                rsp_valid_q <= 1'b1;
                            end
                        end
                    end else if (cnt_q + 1'b1 == CNT_W'(RD_TIMEOUT)) begin
                        rd_en_q     <= 1'b0;
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        illegal_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    wr_en_q     <= 1'b0;
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.csr_rd_en   = rd_en_q;
    assign bus.csr_wr_en   = wr_en_q;
    assign bus.csr_addr    = addr_q;
    assign bus.csr_wr_data = new_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rd_data = rdat_q;
    assign bus.rsp_illegal = illegal_q;
endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// Directed bench for csr_rmw_ctrl: a tiny CSR-file responder plus one task
// per scenario with hand-computed expectations.
module tb_csr_rmw_ctrl;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    csr_rmw_if #(.XLEN(32), .CSR_ADDR_W(12)) bus ();

    csr_rmw_ctrl #(.XLEN(32), .CSR_ADDR_W(12), .RD_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: answers in the same cycle as the read request.
    logic        rd_auto;
    logic        rd_err_mode;
    logic [31:0] csr_val;
    assign bus.csr_rd_valid = bus.csr_rd_en & rd_auto;
    assign bus.csr_rd_err   = rd_err_mode;
    assign bus.csr_rd_data  = csr_val;

    // Port activity monitor.
    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic [31:0] last_wr;
    logic [11:0] last_wr_addr;
    always @(posedge clk) if (rst_n) begin
        if (bus.csr_wr_en) begin
            wr_cnt++;
            last_wr      = bus.csr_wr_data;
            last_wr_addr = bus.csr_addr;
        end
        if (bus.csr_rd_en) rd_cnt++;
        if (bus.csr_rd_en && bus.csr_wr_en) both_cnt++;
    end

    // Issue one request, wait for the response, complete the handshake.
    task automatic do_req(input logic [2:0] f3, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] zimm,
                          input logic rs1x0, input logic rdx0,
                          output int lat, output logic [31:0] rdata,
                          output logic ill, output int nrd, output int nwr);
        int rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        bus.req_funct3    = f3;
        bus.req_csr_addr  = addr;
        bus.req_rs1_val   = rs1;
        bus.req_zimm      = zimm;
        bus.req_rs1_is_x0 = rs1x0;
        bus.req_rd_is_x0  = rdx0;
        bus.req_valid     = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = bus.rsp_rd_data;
        ill   = bus.rsp_illegal;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    task automatic test_reset;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
        end
        checks++;
        if ({bus.rsp_valid, bus.csr_rd_en, bus.csr_wr_en, bus.rsp_illegal} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0000",
                               {bus.rsp_valid, bus.csr_rd_en, bus.csr_wr_en, bus.rsp_illegal});
        end
        checks++;
        if ({bus.rsp_rd_data, bus.csr_wr_data, bus.csr_addr} !== 76'd0) begin
            errors++; $display("FAIL reset_data got=%h exp=0",
                               {bus.rsp_rd_data, bus.csr_wr_data, bus.csr_addr});
        end
    endtask

    task automatic test_csrrs;
        int lat, nrd, nwr; logic [31:0] d; logic il;
        csr_val = 32'h1;
        do_req(3'b010, 12'h300, 32'h8, 5'd0, 1'b0, 1'b0, lat, d, il, nrd, nwr);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rs_latency got=%0d exp=3", lat); end
        checks++;
        if (nwr !== 1 || last_wr !== 32'h9 || last_wr_addr !== 12'h300) begin
            errors++; $display("FAIL rs_write got=%0d/%h@%h exp=1/9@300", nwr, last_wr, last_wr_addr);
        end
        checks++;
        if (d !== 32'h1 || il !== 1'b0 || nrd !== 1) begin
            errors++; $display("FAIL rs_rsp got=%h/%b/%0d exp=1/0/1", d, il, nrd);
        end
        // rs1 = x0: pure read at minimum latency
        csr_val = 32'h1234;
        do_req(3'b010, 12'h300, 32'hFFFF, 5'd0, 1'b1, 1'b0, lat, d, il, nrd, nwr);
        checks++;
        if (lat !== 2 || nwr !== 0 || d !== 32'h1234 || il !== 1'b0) begin
            errors++; $display("FAIL rs_x0 got=lat%0d/w%0d/%h/%b exp=lat2/w0/1234/0", lat, nwr, d, il);
        end
    endtask

    task automatic test_csrrci_ro;
        int lat, nrd, nwr; logic [31:0] d; logic il;
        csr_val = 32'hABCD;
        do_req(3'b111, 12'hC00, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, lat, d, il, nrd, nwr);
        checks++;
        if (nrd !== 1 || nwr !== 0 || d !== 32'hABCD || il !== 1'b0) begin
            errors++; $display("FAIL rci_ro got=r%0d/w%0d/%h/%b exp=r1/w0/abcd/0", nrd, nwr, d, il);
        end
        // RS with nonzero source on a read-only CSR is illegal
        do_req(3'b010, 12'hC00, 32'h1, 5'd0, 1'b0, 1'b0, lat, d, il, nrd, nwr);
        checks++;
        if (nwr !== 0 || d !== 32'h0 || il !== 1'b1) begin
            errors++; $display("FAIL rs_ro_illegal got=w%0d/%h/%b exp=w0/0/1", nwr, d, il);
        end
    endtask

    task automatic test_csrrwi_skip;
        int lat, nrd, nwr; logic [31:0] d; logic il;
        csr_val = 32'h7777;
        do_req(3'b101, 12'h340, 32'hFFFF, 5'd5, 1'b0, 1'b1, lat, d, il, nrd, nwr);
        checks++;
        if (nrd !== 0 || nwr !== 1 || last_wr !== 32'h5 || last_wr_addr !== 12'h340) begin
            errors++; $display("FAIL rwi_skip got=r%0d/w%0d/%h@%h exp=r0/w1/5@340", nrd, nwr, last_wr, last_wr_addr);
        end
        checks++;
        if (d !== 32'h0 || il !== 1'b0 || lat !== 2) begin
            errors++; $display("FAIL rwi_rsp got=%h/%b/lat%0d exp=0/0/lat2", d, il, lat);
        end
        do_req(3'b101, 12'hC01, 32'hFFFF, 5'd5, 1'b0, 1'b1, lat, d, il, nrd, nwr);
        checks++;
        if (nrd !== 0 || nwr !== 0 || il !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL rwi_ro got=r%0d/w%0d/%b/%h exp=r0/w0/1/0", nrd, nwr, il, d);
        end
    endtask

    task automatic test_csrrw_rc;
        int lat, nrd, nwr; logic [31:0] d; logic il;
        csr_val = 32'h55;
        do_req(3'b001, 12'h305, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, lat, d, il, nrd, nwr);
        checks++;
        if (lat !== 3 || nwr !== 1 || last_wr !== 32'hDEAD_BEEF || d !== 32'h55 || il !== 1'b0) begin
            errors++; $display("FAIL rw got=lat%0d/w%0d/%h/%h/%b exp=lat3/w1/deadbeef/55/0", lat, nwr, last_wr, d, il);
        end
        csr_val = 32'hFF;
        do_req(3'b011, 12'h304, 32'hF0, 5'd0, 1'b0, 1'b0, lat, d, il, nrd, nwr);
        checks++;
        if (nwr !== 1 || last_wr !== 32'h0F || d !== 32'hFF || il !== 1'b0) begin
            errors++; $display("FAIL rc got=w%0d/%h/%h/%b exp=w1/0f/ff/0", nwr, last_wr, d, il);
        end
        // RSI with unchanged value still writes
        csr_val = 32'h3;
        do_req(3'b110, 12'h304, 32'h0, 5'd1, 1'b0, 1'b0, lat, d, il, nrd, nwr);
        checks++;
        if (nwr !== 1 || last_wr !== 32'h3 || d !== 32'h3) begin
            errors++; $display("FAIL rsi_same got=w%0d/%h/%h exp=w1/3/3", nwr, last_wr, d);
        end
    endtask

    task automatic test_illegal;
        int lat, nrd, nwr; logic [31:0] d; logic il;
        csr_val = 32'h99;
        do_req(3'b100, 12'h300, 32'h1, 5'd1, 1'b0, 1'b0, lat, d, il, nrd, nwr);
        checks++;
        if (lat !== 1 || il !== 1'b1 || nrd !== 0 || nwr !== 0 || d !== 32'h0) begin
            errors++; $display("FAIL f3_illegal got=lat%0d/%b/r%0d/w%0d/%h exp=lat1/1/r0/w0/0", lat, il, nrd, nwr, d);
        end
        rd_err_mode = 1'b1;
        do_req(3'b001, 12'h300, 32'h1, 5'd0, 1'b0, 1'b0, lat, d, il, nrd, nwr);
        rd_err_mode = 1'b0;
        checks++;
        if (il !== 1'b1 || nwr !== 0 || d !== 32'h0 || nrd !== 1) begin
            errors++; $display("FAIL rd_err got=%b/w%0d/%h/r%0d exp=1/w0/0/r1", il, nwr, d, nrd);
        end
        rd_auto = 1'b0;
        do_req(3'b010, 12'h300, 32'h1, 5'd0, 1'b0, 1'b0, lat, d, il, nrd, nwr);
        rd_auto = 1'b1;
        checks++;
        if (lat !== 17 || nrd !== 16 || il !== 1'b1 || nwr !== 0 || d !== 32'h0) begin
            errors++; $display("FAIL timeout got=lat%0d/r%0d/%b/w%0d/%h exp=lat17/r16/1/w0/0", lat, nrd, il, nwr, d);
        end
    endtask

    task automatic test_hold;
        int n, bad;
        csr_val = 32'hCAFE;
        bus.req_funct3 = 3'b010; bus.req_csr_addr = 12'h341; bus.req_rs1_is_x0 = 1'b1;
        bus.req_rd_is_x0 = 1'b0; bus.req_rs1_val = 32'h0; bus.req_zimm = 5'd0;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!bus.rsp_valid || bus.rsp_rd_data !== 32'hCAFE || bus.rsp_illegal !== 1'b0 || bus.req_ready !== 1'b0)
                bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL hold_stable got=%0d bad cycles exp=0", bad); end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release got=v%b/r%b exp=v0/r1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_mid;
        int wr0;
        rd_auto = 1'b0;
        bus.req_funct3 = 3'b001; bus.req_csr_addr = 12'h300; bus.req_rs1_val = 32'h1234;
        bus.req_rs1_is_x0 = 1'b0; bus.req_rd_is_x0 = 1'b0;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.csr_rd_en !== 1'b1) begin errors++; $display("FAIL mid_in_read got=%b exp=1", bus.csr_rd_en); end
        wr0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || {bus.csr_rd_en, bus.csr_wr_en, bus.rsp_valid, bus.rsp_illegal} !== 4'b0) begin
            errors++; $display("FAIL mid_reset got=r%b/%b exp=r1/0000", bus.req_ready,
                               {bus.csr_rd_en, bus.csr_wr_en, bus.rsp_valid, bus.rsp_illegal});
        end
        rd_auto = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt !== wr0 || bus.csr_rd_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_after got=w%0d/r%b/v%b exp=w%0d/r0/v0", wr_cnt, bus.csr_rd_en, bus.rsp_valid, wr0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rd_auto = 1'b1; rd_err_mode = 1'b0; csr_val = 32'h0;
        bus.req_valid = 1'b0; bus.req_funct3 = 3'b0; bus.req_csr_addr = 12'h0;
        bus.req_rs1_val = 32'h0; bus.req_zimm = 5'd0; bus.req_rs1_is_x0 = 1'b0;
        bus.req_rd_is_x0 = 1'b0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_csrrs;
        test_csrrci_ro;
        test_csrrwi_skip;
        test_csrrw_rc;
        test_illegal;
        test_hold;
        test_reset_mid;
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL rd_wr_overlap got=%0d exp=0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_rmw_ctrl.md
Name: csr_rmw_ctrl

Overview:
- Sequences the read-modify-write of the CSR file for decoded SYSTEM/CSR instructions (CSRRW/S/C and their immediate forms).
- Accepts one decoded request from decode/execute and issues the CSR-file read, then the write.
- Returns the old CSR value for rd, or flags the instruction illegal.
- Sits between the execute stage and the CSR register file. The immediate forms use the 5-bit zero-extended zimm operand.

Parameters:
XLEN, 32, data width of CSR values and rs1 operand
CSR_ADDR_W, 12, CSR address width
RD_TIMEOUT, 16, max cycles to wait for csr_rd_valid before flagging illegal (>=1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  decoded CSR request valid
req_ready  output  1  controller can accept a request
req_funct3  input  3  instruction funct3; bit2 selects immediate operand
req_csr_addr  input  CSR_ADDR_W  target CSR address
req_rs1_val  input  XLEN  rs1 register value
req_zimm  input  5  immediate operand (rs1 field)
req_rs1_is_x0  input  1  rs1 field is x0
req_rd_is_x0  input  1  rd field is x0
csr_rd_en  output  1  CSR-file read request (held until csr_rd_valid)
csr_addr  output  CSR_ADDR_W  CSR-file address for read/write
csr_rd_data  input  XLEN  CSR-file read data
csr_rd_valid  input  1  read data valid; may be asserted in the same cycle as csr_rd_en
csr_rd_err  input  1  CSR nonexistent/inaccessible, qualified by csr_rd_valid
csr_wr_en  output  1  CSR-file write strobe, single cycle
csr_wr_data  output  XLEN  CSR-file write data
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_rd_data  output  XLEN  old CSR value for rd (0 if illegal or read skipped)
rsp_illegal  output  1  illegal-instruction flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; latches and timeout counter cleared.
  - All outputs 0 except req_ready=1.
  - Reset mid-operation aborts the request. No write is issued after release.
- States: IDLE, READ, WRITE, RESP. req_ready=1 only in IDLE.
- IDLE:
  - On req_valid, latch all req_* fields.
  - operand = funct3[2] ? {zero-ext zimm} : rs1_val.
  - src_zero = funct3[2] ? (zimm==0) : rs1_is_x0.
  - Next state:
    - funct3[1:0]==00 -> RESP, illegal.
    - RW/RWI (funct3[1:0]==01) with rd_is_x0 -> WRITE; read skipped, no read side effects.
    - Otherwise -> READ.
- READ:
  - csr_rd_en=1 and csr_addr=latched addr until csr_rd_valid; the counter increments each cycle.
  - On csr_rd_valid & csr_rd_err -> RESP, illegal.
  - On csr_rd_valid & !err:
    - Latch old=csr_rd_data.
    - new = RW: operand; RS: old|operand; RC: old & ~operand.
    - write_needed = RW ? 1 : !src_zero. RS/RC with a nonzero source write even if the value is unchanged.
  - Counter reaches RD_TIMEOUT without valid -> RESP, illegal.
- Read-only check: write_needed & csr_addr[11:10]==2'b11 -> RESP, illegal, no write. Applies on the skipped-read path as well.
- Leaving READ (no error): write_needed -> WRITE; else -> RESP.
- WRITE: csr_wr_en=1 for exactly one cycle, csr_wr_data=new, csr_addr=latched addr -> RESP.
- RESP:
  - rsp_valid=1, rsp_rd_data and rsp_illegal held stable until rsp_ready.
  - Transfer cycle -> IDLE. The next request is accepted the cycle after.
  - Illegal responses force rsp_rd_data=0.
- Minimum latency, CSRRS rs1=x0 with combinational rd_valid: accept T, READ T+1, rsp_valid T+2.
- CSRRW: accept T, READ T+1, WRITE T+2, rsp_valid T+3.
- csr_wr_en is never asserted on any illegal path. csr_rd_en and csr_wr_en are never both high.

Test Plan:
- CSRRS addr 0x300, rs1_val 0x8, CSR holds 0x1, rd_valid same cycle -> one write of 0x9, rsp_rd_data=0x1, rsp_illegal=0, rsp_valid at T+3.
- CSRRCI zimm=0, addr 0xC00 (read-only) -> read only, no csr_wr_en, rsp_rd_data=CSR value, rsp_illegal=0.
- CSRRWI zimm=5, rd=x0, addr 0x340 -> no csr_rd_en, one write of 0x5, rsp_rd_data=0; same request to addr 0xC01 -> illegal, no write.
- funct3=100 -> no CSR access, rsp_illegal=1 at T+1; csr_rd_err=1 on read -> illegal, no write; rd_valid withheld -> illegal after 16 cycles.
- Hold rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready=0; assert rst_n=0 while in READ -> outputs 0, req_ready=1, no write after release.
